// File: rtl/sequencer_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : sequencer_ctl
//  Description : Run-scheduler for the DSP sequencer. Each sample-frame
//                strobe becomes one complete sequencer program run. The
//                sequencer is held in reset between runs and released once
//                per frame. The block waits for done, aborts on timeout, and
//                swaps the coefficient bank only while no run is active.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    ck           in   clock
//    rst          in   asynchronous reset, active high
//    sample_stb   in   1-cycle pulse: a new audio frame has been written
//    seq_done     in   sequencer finished its program
//    seq_error    in   sequencer reports an error
//    swap_req     in   1-cycle pulse: request coefficient bank swap
//    status_clr   in   1-cycle pulse: clear sticky status
//    seq_rst      out  sequencer reset (1 = held, 0 = running)
//    frame        out  frame index of the current run, stable for the run
//    bank         out  coefficient bank select
//    swap_ack     out  1-cycle pulse when bank toggles
//    busy         out  high in RUN or GAP
//    frame_done   out  1-cycle pulse on successful run completion
//    last_cycles  out  length in cycles of the last successful run
//    err_seq      out  sticky: seq_error seen during a run
//    err_timeout  out  sticky: a run was aborted by timeout
//    overrun_cnt  out  saturating count of dropped strobes
// ============================================================================
module sequencer_ctl #(
  parameter int FRAME_W = 4,
  parameter int CYC_W   = 10,
  parameter int TIMEOUT = 1000,
  parameter int GAP     = 4,
  parameter int OVR_W   = 8
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               sample_stb,
  input  logic               seq_done,
  input  logic               seq_error,
  input  logic               swap_req,
  input  logic               status_clr,
  output logic               seq_rst,
  output logic [FRAME_W-1:0] frame,
  output logic               bank,
  output logic               swap_ack,
  output logic               busy,
  output logic               frame_done,
  output logic [CYC_W-1:0]   last_cycles,
  output logic               err_seq,
  output logic               err_timeout,
  output logic [OVR_W-1:0]   overrun_cnt
);

  // Gap counter only has to reach GAP-1.
  localparam int                  c_GAP_W    = $clog2(GAP);
  localparam logic [c_GAP_W-1:0]  c_GAP_LAST = c_GAP_W'(GAP - 1);
  localparam logic [CYC_W:0]      c_TIMEOUT  = (CYC_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t               r_state;
  logic [CYC_W-1:0]     r_cnt;
  logic [c_GAP_W-1:0]   r_gap_cnt;
  logic [FRAME_W-1:0]   r_wr_frame;
  logic                 r_pending;
  logic                 r_swap_pend;

  logic [FRAME_W-1:0]   w_wr_frame_inc;
  logic [CYC_W:0]       w_run_len;
  logic [CYC_W-1:0]     w_run_len_sat;
  logic                 w_timeout_hit;
  logic                 w_in_idle;
  logic                 w_in_run;
  logic                 w_toggle;
  logic                 w_start;
  logic                 w_drop;
  logic                 w_ovr_full;
  logic [OVR_W-1:0]     w_ovr_inc;

  assign w_wr_frame_inc = r_wr_frame + FRAME_W'(1);

  // Cycle number of the current RUN edge: the first edge after entry is 1.
  assign w_run_len     = {1'b0, r_cnt} + (CYC_W + 1)'(1);
  assign w_run_len_sat = w_run_len[CYC_W] ? {CYC_W{1'b1}} : w_run_len[CYC_W-1:0];
  assign w_timeout_hit = (w_run_len == c_TIMEOUT);

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_in_run  = (r_state == ST_RUN);

  // A pending swap is serviced before a pending run, so the new run sees
  // the new bank.
  assign w_toggle = w_in_idle && r_swap_pend;
  assign w_start  = w_in_idle && !r_swap_pend && r_pending;

  // A strobe that arrives while one is already queued is lost. This includes
  // the edge on which the queued strobe starts its run; that strobe is still
  // folded into the frame index of the run.
  assign w_drop     = sample_stb && r_pending;
  assign w_ovr_full = &overrun_cnt;
  assign w_ovr_inc  = w_ovr_full ? overrun_cnt : overrun_cnt + OVR_W'(1);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_gap_cnt   <= '0;
      r_wr_frame  <= '0;
      r_pending   <= 1'b0;
      r_swap_pend <= 1'b0;
      seq_rst     <= 1'b1;
      frame       <= '0;
      bank        <= 1'b0;
      swap_ack    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      last_cycles <= '0;
      err_seq     <= 1'b0;
      err_timeout <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      swap_ack   <= 1'b0;
      frame_done <= 1'b0;

      // Write-side frame index advances on every strobe, dropped or not.
      if (sample_stb) begin
        r_wr_frame <= w_wr_frame_inc;
      end

      if (w_start) begin
        r_pending <= 1'b0;
      end else if (sample_stb) begin
        r_pending <= 1'b1;
      end

      // Setting events take priority over status_clr.
      if (w_drop) begin
        overrun_cnt <= status_clr ? OVR_W'(1) : w_ovr_inc;
      end else if (status_clr) begin
        overrun_cnt <= '0;
      end

      if (w_in_run && seq_error) begin
        err_seq <= 1'b1;
      end else if (status_clr) begin
        err_seq <= 1'b0;
      end

      if (w_in_run && !seq_done && w_timeout_hit) begin
        err_timeout <= 1'b1;
      end else if (status_clr) begin
        err_timeout <= 1'b0;
      end

      if (swap_req) begin
        r_swap_pend <= 1'b1;
      end else if (w_toggle) begin
        r_swap_pend <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_swap_pend) begin
            bank     <= ~bank;
            swap_ack <= 1'b1;
          end else if (r_pending) begin
            r_state <= ST_RUN;
            seq_rst <= 1'b0;
            busy    <= 1'b1;
            r_cnt   <= '0;
            // Use the newest frame index, including a strobe on this edge.
            frame   <= sample_stb ? w_wr_frame_inc : r_wr_frame;
          end
        end

        ST_RUN: begin
          r_cnt <= w_run_len_sat;
          if (seq_done) begin
            r_state     <= ST_GAP;
            seq_rst     <= 1'b1;
            r_gap_cnt   <= '0;
            last_cycles <= w_run_len_sat;
            frame_done  <= 1'b1;
          end else if (w_timeout_hit) begin
            r_state   <= ST_GAP;
            seq_rst   <= 1'b1;
            r_gap_cnt <= '0;
          end
        end

        ST_GAP: begin
          // Sequencer is draining; its done/error lines are ignored here.
          if (r_gap_cnt == c_GAP_LAST) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          seq_rst <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sequencer_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequencer_ctl
//  Description : Directed self-checking bench for sequencer_ctl. Each task
//                resets the block and exercises one scenario with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sequencer_ctl;

  localparam int FRAME_W = 4;
  localparam int CYC_W   = 10;
  localparam int TIMEOUT = 50;
  localparam int GAP     = 4;
  localparam int OVR_W   = 8;

  logic               ck;
  logic               rst;
  logic               sample_stb;
  logic               seq_done;
  logic               seq_error;
  logic               swap_req;
  logic               status_clr;
  logic               seq_rst;
  logic [FRAME_W-1:0] frame;
  logic               bank;
  logic               swap_ack;
  logic               busy;
  logic               frame_done;
  logic [CYC_W-1:0]   last_cycles;
  logic               err_seq;
  logic               err_timeout;
  logic [OVR_W-1:0]   overrun_cnt;

  int n_checks = 0;
  int n_errors = 0;

  sequencer_ctl #(
    .FRAME_W (FRAME_W),
    .CYC_W   (CYC_W),
    .TIMEOUT (TIMEOUT),
    .GAP     (GAP),
    .OVR_W   (OVR_W)
  ) u_dut (
    .ck          (ck),
    .rst         (rst),
    .sample_stb  (sample_stb),
    .seq_done    (seq_done),
    .seq_error   (seq_error),
    .swap_req    (swap_req),
    .status_clr  (status_clr),
    .seq_rst     (seq_rst),
    .frame       (frame),
    .bank        (bank),
    .swap_ack    (swap_ack),
    .busy        (busy),
    .frame_done  (frame_done),
    .last_cycles (last_cycles),
    .err_seq     (err_seq),
    .err_timeout (err_timeout),
    .overrun_cnt (overrun_cnt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    sample_stb = 1'b0;
    seq_done   = 1'b0;
    seq_error  = 1'b0;
    swap_req   = 1'b0;
    status_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Strobe on one edge; the run begins on the following edge.
  task automatic start_run();
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (seq_rst !== 1'b1) begin n_errors++; $display("FAIL reset_seq_rst got %0h want 1", seq_rst); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0h want 0", busy); end
    n_checks++; if (frame !== 4'd0 || bank !== 1'b0) begin n_errors++; $display("FAIL reset_frame_bank got %0h/%0h want 0/0", frame, bank); end
    n_checks++; if (last_cycles !== 10'd0 || overrun_cnt !== 8'd0 || err_seq !== 1'b0 || err_timeout !== 1'b0)
      begin n_errors++; $display("FAIL reset_status got lc=%0d ovr=%0d es=%0h et=%0h want all 0", last_cycles, overrun_cnt, err_seq, err_timeout); end
    n_checks++; if (swap_ack !== 1'b0 || frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_pulses got %0h/%0h want 0/0", swap_ack, frame_done); end
  endtask

  task automatic test_basic_run();
    do_reset();
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    n_checks++; if (seq_rst !== 1'b1) begin n_errors++; $display("FAIL run_not_yet got %0h want 1", seq_rst); end
    tick();
    n_checks++; if (seq_rst !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL run_start got rst=%0h busy=%0h want 0/1", seq_rst, busy); end
    n_checks++; if (frame !== 4'd1) begin n_errors++; $display("FAIL run_frame got %0d want 1", frame); end
    repeat (19) tick();
    n_checks++; if (seq_rst !== 1'b0 || frame_done !== 1'b0) begin n_errors++; $display("FAIL run_edge19 got rst=%0h fd=%0h want 0/0", seq_rst, frame_done); end
    seq_done = 1'b1;
    tick();
    n_checks++; if (seq_rst !== 1'b1 || frame_done !== 1'b1) begin n_errors++; $display("FAIL done_edge got rst=%0h fd=%0h want 1/1", seq_rst, frame_done); end
    n_checks++; if (last_cycles !== 10'd20) begin n_errors++; $display("FAIL last_cycles got %0d want 20", last_cycles); end
    // seq_done left high through GAP must be ignored
    tick();
    n_checks++; if (frame_done !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL gap1 got fd=%0h busy=%0h want 0/1", frame_done, busy); end
    seq_done = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL gap3_busy got %0h want 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0 || seq_rst !== 1'b1) begin n_errors++; $display("FAIL gap_end got busy=%0h rst=%0h want 0/1", busy, seq_rst); end
    n_checks++; if (err_seq !== 1'b0 || err_timeout !== 1'b0) begin n_errors++; $display("FAIL basic_flags got %0h/%0h want 0/0", err_seq, err_timeout); end
  endtask

  task automatic test_overrun();
    do_reset();
    start_run();
    n_checks++; if (frame !== 4'd1) begin n_errors++; $display("FAIL ovr_run1_frame got %0d want 1", frame); end
    sample_stb = 1'b1;
    tick();
    n_checks++; if (overrun_cnt !== 8'd0) begin n_errors++; $display("FAIL ovr_second got %0d want 0", overrun_cnt); end
    tick();
    sample_stb = 1'b0;
    n_checks++; if (overrun_cnt !== 8'd1) begin n_errors++; $display("FAIL ovr_third got %0d want 1", overrun_cnt); end
    n_checks++; if (frame !== 4'd1) begin n_errors++; $display("FAIL ovr_frame_stable got %0d want 1", frame); end
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
    repeat (4) tick();
    n_checks++; if (busy !== 1'b0 || seq_rst !== 1'b1) begin n_errors++; $display("FAIL ovr_idle got busy=%0h rst=%0h want 0/1", busy, seq_rst); end
    tick();
    n_checks++; if (seq_rst !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL ovr_run2 got rst=%0h busy=%0h want 0/1", seq_rst, busy); end
    n_checks++; if (frame !== 4'd3) begin n_errors++; $display("FAIL ovr_run2_frame got %0d want 3", frame); end
    n_checks++; if (overrun_cnt !== 8'd1) begin n_errors++; $display("FAIL ovr_hold got %0d want 1", overrun_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    start_run();
    repeat (TIMEOUT - 1) tick();
    n_checks++; if (seq_rst !== 1'b0 || err_timeout !== 1'b0) begin n_errors++; $display("FAIL to_edge49 got rst=%0h et=%0h want 0/0", seq_rst, err_timeout); end
    tick();
    n_checks++; if (seq_rst !== 1'b1 || err_timeout !== 1'b1) begin n_errors++; $display("FAIL to_edge50 got rst=%0h et=%0h want 1/1", seq_rst, err_timeout); end
    n_checks++; if (frame_done !== 1'b0 || last_cycles !== 10'd0) begin n_errors++; $display("FAIL to_no_done got fd=%0h lc=%0d want 0/0", frame_done, last_cycles); end
    repeat (4) tick();
    n_checks++; if (busy !== 1'b0 || err_timeout !== 1'b1) begin n_errors++; $display("FAIL to_sticky got busy=%0h et=%0h want 0/1", busy, err_timeout); end
  endtask

  task automatic test_swap();
    logic bank_moved;
    do_reset();
    start_run();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    n_checks++; if (bank !== 1'b0 || swap_ack !== 1'b0) begin n_errors++; $display("FAIL swap_in_run got bank=%0h ack=%0h want 0/0", bank, swap_ack); end
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
    bank_moved = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bank !== 1'b0 || swap_ack !== 1'b0) bank_moved = 1'b1;
    end
    n_checks++; if (bank_moved !== 1'b0) begin n_errors++; $display("FAIL swap_in_gap got moved=%0h want 0", bank_moved); end
    tick();
    n_checks++; if (bank !== 1'b1 || swap_ack !== 1'b1 || seq_rst !== 1'b1) begin n_errors++; $display("FAIL swap_toggle got bank=%0h ack=%0h rst=%0h want 1/1/1", bank, swap_ack, seq_rst); end
    tick();
    n_checks++; if (seq_rst !== 1'b0 || swap_ack !== 1'b0 || bank !== 1'b1) begin n_errors++; $display("FAIL swap_then_run got rst=%0h ack=%0h bank=%0h want 0/0/1", seq_rst, swap_ack, bank); end
    n_checks++; if (frame !== 4'd2) begin n_errors++; $display("FAIL swap_run_frame got %0d want 2", frame); end
  endtask

  task automatic test_status();
    do_reset();
    start_run();
    seq_error = 1'b1;
    tick();
    seq_error = 1'b0;
    n_checks++; if (err_seq !== 1'b1) begin n_errors++; $display("FAIL es_set got %0h want 1", err_seq); end
    tick();
    n_checks++; if (err_seq !== 1'b1) begin n_errors++; $display("FAIL es_hold got %0h want 1", err_seq); end
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    n_checks++; if (err_seq !== 1'b0) begin n_errors++; $display("FAIL es_clear got %0h want 0", err_seq); end
    sample_stb = 1'b1;
    tick();
    status_clr = 1'b1;
    tick();
    sample_stb = 1'b0;
    status_clr = 1'b0;
    n_checks++; if (overrun_cnt !== 8'd1) begin n_errors++; $display("FAIL clr_vs_drop got %0d want 1", overrun_cnt); end
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    n_checks++; if (overrun_cnt !== 8'd0) begin n_errors++; $display("FAIL ovr_clear got %0d want 0", overrun_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    start_run();
    repeat (5) tick();
    n_checks++; if (bank !== 1'b1 || frame !== 4'd1 || seq_rst !== 1'b0) begin n_errors++; $display("FAIL ar_pre got bank=%0h frame=%0d rst=%0h want 1/1/0", bank, frame, seq_rst); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (seq_rst !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL ar_now got rst=%0h busy=%0h want 1/0", seq_rst, busy); end
    n_checks++; if (frame !== 4'd0 || bank !== 1'b0) begin n_errors++; $display("FAIL ar_regs got frame=%0d bank=%0h want 0/0", frame, bank); end
    #3;
    rst = 1'b0;
    tick();
    n_checks++; if (seq_rst !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL ar_after got rst=%0h busy=%0h want 1/0", seq_rst, busy); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_overrun();
    test_timeout();
    test_swap();
    test_status();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
